// File: rtl/hvac_scheduler.sv
// Schedules heater/cooler drive from raw heat/cool requests, enforcing minimum
// run time, minimum off time and a changeover dead time between opposite modes.
module hvac_scheduler #(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 6,
  parameter int DEAD    = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heating,
  output logic       cooling,
  output logic [2:0] state,
  output logic       conflict
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEAT   = 3'd1,
    ST_COOL   = 3'd2,
    ST_OFF    = 3'd3,
    ST_CHANGE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_COOL = 2'd2
  } mode_e;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

  state_e           state_q, state_d;
  mode_e            last_q, last_d;
  mode_e            target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;
  logic             heating_q, cooling_q;

  logic both_req;
  logic heat_only;
  logic cool_only;

  assign both_req  = heat_req & cool_req;
  assign heat_only = enable & heat_req & ~cool_req;
  assign cool_only = enable & cool_req & ~heat_req;

  // NOTE: every variable gets its default before the case so no path leaves
  // a value unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    target_d   = target_q;
    conflict_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && both_req) begin
          conflict_d = 1'b1;
        end else if (heat_only) begin
          if (last_q == MODE_COOL) begin
            state_d  = ST_CHANGE;
            target_d = MODE_HEAT;
          end else begin
            state_d = ST_HEAT;
          end
        end else if (cool_only) begin
          if (last_q == MODE_HEAT) begin
            state_d  = ST_CHANGE;
            target_d = MODE_COOL;
          end else begin
            state_d = ST_COOL;
          end
        end
      end
      ST_HEAT: begin
        if (cnt_q >= ON_LAST && (!heat_req || !enable)) begin
          state_d = ST_OFF;
          last_d  = MODE_HEAT;
        end
      end
      ST_COOL: begin
        if (cnt_q >= ON_LAST && (!cool_req || !enable)) begin
          state_d = ST_OFF;
          last_d  = MODE_COOL;
        end
      end
      ST_OFF: begin
        if (cnt_q == OFF_LAST) state_d = ST_IDLE;
      end
      ST_CHANGE: begin
        if (cnt_q == DEAD_LAST) begin
          if (both_req) begin
            state_d    = ST_IDLE;
            conflict_d = 1'b1;
          end else if (enable && target_q == MODE_HEAT && heat_req) begin
            state_d = ST_HEAT;
          end else if (enable && target_q == MODE_COOL && cool_req) begin
            state_d = ST_COOL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The phase counter restarts on every state entry and saturates, so a long
  // held request never wraps back under the minimum-run threshold.
  always_comb begin
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
    else                     cnt_d = cnt_q;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= MODE_NONE;
      target_q   <= MODE_NONE;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      heating_q  <= 1'b0;
      cooling_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      heating_q  <= (state_d == ST_HEAT);
      cooling_q  <= (state_d == ST_COOL);
    end
  end

  assign heating  = heating_q;
  assign cooling  = cooling_q;
  assign state    = state_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_hvac_scheduler.sv
// Self-checking bench for hvac_scheduler: timestamp-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_hvac_scheduler;

  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 6;
  localparam int DEAD    = 4;
  localparam int CNT_W   = 8;

  localparam int IDLE = 0, HEAT = 1, COOL = 2, OFF = 3, CHANGE = 4;
  localparam int M_NONE = 0, M_HEAT = 1, M_COOL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       heat_req = 1'b0;
  logic       cool_req = 1'b0;
  logic       heating;
  logic       cooling;
  logic [2:0] state;
  logic       conflict;

  int n_chk = 0;
  int n_err = 0;

  hvac_scheduler #(
    .MIN_ON (MIN_ON),
    .MIN_OFF(MIN_OFF),
    .DEAD   (DEAD),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .heat_req(heat_req),
    .cool_req(cool_req),
    .heating (heating),
    .cooling (cooling),
    .state   (state),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each phase is described by the edge index at which it
  // began; phase ends are computed as elapsed-edge arithmetic.
  int cyc = 0;
  int m_state = IDLE;
  int m_last = M_NONE;
  int m_target = M_NONE;
  int m_since = 0;
  bit m_conflict = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin : model
    int ns, nl, nt, el;
    bit nc;
    if (rst) begin
      m_state    <= IDLE;
      m_last     <= M_NONE;
      m_target   <= M_NONE;
      m_conflict <= 1'b0;
      m_since    <= cyc;
    end else begin
      ns = m_state;
      nl = m_last;
      nt = m_target;
      nc = 1'b0;
      el = cyc - m_since;
      case (m_state)
        IDLE: begin
          if (enable && heat_req && cool_req) nc = 1'b1;
          else if (enable && heat_req) begin
            if (m_last == M_COOL) begin ns = CHANGE; nt = M_HEAT; end
            else ns = HEAT;
          end else if (enable && cool_req) begin
            if (m_last == M_HEAT) begin ns = CHANGE; nt = M_COOL; end
            else ns = COOL;
          end
        end
        HEAT: if (el >= MIN_ON && !(heat_req && enable)) begin ns = OFF; nl = M_HEAT; end
        COOL: if (el >= MIN_ON && !(cool_req && enable)) begin ns = OFF; nl = M_COOL; end
        OFF:  if (el == MIN_OFF) ns = IDLE;
        CHANGE: begin
          if (el == DEAD) begin
            if (heat_req && cool_req) begin ns = IDLE; nc = 1'b1; end
            else if (enable && ((m_target == M_HEAT && heat_req) ||
                                (m_target == M_COOL && cool_req))) ns = m_target;
            else ns = IDLE;
          end
        end
        default: ns = IDLE;
      endcase
      if (ns != m_state) m_since <= cyc;
      m_state    <= ns;
      m_last     <= nl;
      m_target   <= nt;
      m_conflict <= nc;
    end
  end

  always @(negedge clk) begin
    check("state", int'(state), m_state);
    check("heating", int'(heating), int'(m_state == HEAT));
    check("cooling", int'(cooling), int'(m_state == COOL));
    check("conflict", int'(conflict), int'(m_conflict));
    check("no_overlap", int'(heating & cooling), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_while(input int st, output int n);
    n = 0;
    while (int'(state) == st && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state), IDLE);
    check("rst_heating", int'(heating), 0);
    check("rst_cooling", int'(cooling), 0);
    check("rst_conflict", int'(conflict), 0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // One-cycle heat request from a fresh reset: MIN_ON run, MIN_OFF off.
    heat_req = 1'b1;
    tick();
    heat_req = 1'b0;
    count_while(HEAT, n);
    check("t2_heat_cycles", n, 8);
    count_while(OFF, n);
    check("t2_off_cycles", n, 6);
    check("t2_back_idle", int'(state), IDLE);

    // Request held for 20 edges: run follows the request.
    heat_req = 1'b1;
    n = 0;
    repeat (20) begin
      tick();
      if (heating) n++;
    end
    heat_req = 1'b0;
    tick();
    check("t3_heat_cycles", n, 20);
    check("t3_heating_fell", int'(heating), 0);
    count_while(OFF, n);
    check("t3_off_cycles", n, 6);

    // Heat pulse then cool held from heating's fall: OFF + IDLE + CHANGE gap.
    heat_req = 1'b1;
    tick();
    heat_req = 1'b0;
    count_while(HEAT, n);
    cool_req = 1'b1;
    n = 0;
    while (!cooling && n < 200) begin
      n++;
      tick();
    end
    check("t4_gap_cycles", n, 11);
    check("t4_cooling_on", int'(cooling), 1);
    cool_req = 1'b0;
    count_while(COOL, n);
    check("t4_cool_cycles", n, 8);
    count_while(OFF, n);

    // Conflicting requests in IDLE, then both high at end of CHANGE.
    heat_req = 1'b1;
    cool_req = 1'b1;
    repeat (3) begin
      tick();
      check("t5_conflict", int'(conflict), 1);
      check("t5_idle", int'(state), IDLE);
    end
    heat_req = 1'b0;
    cool_req = 1'b0;
    tick();
    check("t5_conflict_clear", int'(conflict), 0);
    heat_req = 1'b1;
    tick();
    check("t5_change", int'(state), CHANGE);
    cool_req = 1'b1;
    repeat (3) tick();
    check("t5_still_change", int'(state), CHANGE);
    tick();
    check("t5_change_conflict", int'(conflict), 1);
    check("t5_change_idle", int'(state), IDLE);
    heat_req = 1'b0;
    cool_req = 1'b0;
    tick();
    check("t5_conflict_drop", int'(conflict), 0);

    // enable dropped mid-run does not truncate MIN_ON; no start while disabled.
    heat_req = 1'b1;
    tick();
    check("t6_change", int'(state), CHANGE);
    count_while(CHANGE, n);
    check("t6_dead_cycles", n, 4);
    check("t6_heat", int'(state), HEAT);
    tick();
    tick();
    enable = 1'b0;
    count_while(HEAT, n);
    check("t6_heat_remaining", n, 6);
    check("t6_off", int'(state), OFF);
    count_while(OFF, n);
    repeat (5) tick();
    check("t6_no_start", int'(state), IDLE);
    check("t6_no_heat", int'(heating), 0);
    enable = 1'b1;
    heat_req = 1'b0;
    tick();

    // Reset mid-run clears immediately and forgets the last mode.
    heat_req = 1'b1;
    tick();
    check("t1_heat", int'(state), HEAT);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("t1_rst_heating", int'(heating), 0);
    check("t1_rst_state", int'(state), IDLE);
    heat_req = 1'b0;
    cool_req = 1'b1;
    #2 rst = 1'b0;
    tick();
    check("t1_cool_direct", int'(state), COOL);
    check("t1_cooling", int'(cooling), 1);
    cool_req = 1'b0;
    count_while(COOL, n);
    check("t1_cool_cycles", n, 8);
    count_while(OFF, n);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
